// File: rtl/key_event_fifo_pkg.sv
// ============================================================================
// Module  : key_pkg
// Brief   : Shared constants and interrupt FSM state encoding for key_event_fifo.
// Revision: 1.0
// ============================================================================
`default_nettype none

package key_pkg;
    localparam int KEY_ENTRY_W   = 9;
    localparam int KEY_VALID_BIT = 63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } irq_state_t;
endpackage

`default_nettype wire

// File: rtl/key_event_fifo_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with registered read; a pop on a full FIFO frees
//           the slot for a same-cycle push.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // A pop on an empty FIFO clears the read register so the reader sees "no event".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                if (do_pop) begin
                    dout       <= mem[rd_ptr];
                    dout_valid <= 1'b1;
                    rd_ptr     <= rd_ptr + 1'b1;
                end else begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_event_fifo.sv
// ============================================================================
// Module  : key_event_fifo
// Brief   : Queues PS/2 key events for bus reads and raises an interrupt until
//           acknowledged. Optional release events via KEY_RELEASE_EVENT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_event_fifo #(
    parameter int         DEPTH  = 8,
    parameter logic [3:0] VECTOR = 4'd1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               ascii_code,
    input  logic                     key_pressed,
    input  logic                     key_released,
    input  logic                     rd_en,
    output logic [63:0]              rd_data,
    output logic [3:0]               interrupt_vector,
    input  logic                     interrupt_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    import key_pkg::*;

    logic                   press_d;
    logic                   rd_d;
    logic                   press_req;
    logic                   pop_req;
    logic                   push_req;
    logic [KEY_ENTRY_W-1:0] push_data;
    logic                   drop_release;
    logic [KEY_ENTRY_W-1:0] head;
    logic                   head_valid;
    logic                   fifo_full;
    logic                   fifo_empty;
    irq_state_t             irq_state;

    assign press_req = key_pressed && !press_d && (ascii_code != 8'd0);
    assign pop_req   = rd_en && !rd_d;

`ifdef KEY_RELEASE_EVENT_EN
    logic       release_d;
    logic [7:0] last_ascii;
    logic       release_req;

    assign release_req  = key_released && !release_d;
    assign push_req     = press_req || release_req;
    assign push_data    = press_req ? {1'b0, ascii_code} : {1'b1, last_ascii};
    // Only one entry can be written per cycle; the press wins.
    assign drop_release = press_req && release_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            release_d  <= 1'b0;
            last_ascii <= 8'd0;
        end else begin
            release_d <= key_released;
            if (press_req) begin
                last_ascii <= ascii_code;
            end
        end
    end
`else
    logic unused_release;

    assign unused_release = key_released;
    assign push_req       = press_req;
    assign push_data      = {1'b0, ascii_code};
    assign drop_release   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_d  <= 1'b0;
            rd_d     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            press_d <= key_pressed;
            rd_d    <= rd_en;
            if ((push_req && fifo_full && !pop_req) || drop_release) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (KEY_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_req),
        .pop        (pop_req),
        .din        (push_data),
        .dout       (head),
        .dout_valid (head_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (count)
    );

    always_comb begin
        rd_data                  = '0;
        rd_data[KEY_ENTRY_W-1:0] = head;
        rd_data[KEY_VALID_BIT]   = head_valid;
    end

    // Once acknowledged, the request stays down until the queue has fully drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_state        <= IDLE;
            interrupt_vector <= 4'd0;
        end else begin
            case (irq_state)
                IDLE: begin
                    if (!fifo_empty) begin
                        irq_state        <= REQ;
                        interrupt_vector <= VECTOR;
                    end
                end
                REQ: begin
                    if (interrupt_ack) begin
                        irq_state        <= WAIT;
                        interrupt_vector <= 4'd0;
                    end
                end
                WAIT: begin
                    if (fifo_empty) begin
                        irq_state <= IDLE;
                    end
                end
                default: begin
                    irq_state        <= IDLE;
                    interrupt_vector <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_event_fifo.sv
// ============================================================================
// Module  : tb_key_event_fifo
// Brief   : Directed bench for key_event_fifo (DEPTH=8, VECTOR=1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_event_fifo;

    logic        clk;
    logic        reset;
    logic [7:0]  ascii_code;
    logic        key_pressed;
    logic        key_released;
    logic        rd_en;
    logic [63:0] rd_data;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack;
    logic [3:0]  count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] V = 64'h8000_0000_0000_0000;

    key_event_fifo #(
        .DEPTH  (8),
        .VECTOR (4'd1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ascii_code       (ascii_code),
        .key_pressed      (key_pressed),
        .key_released     (key_released),
        .rd_en            (rd_en),
        .rd_data          (rd_data),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .count            (count),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        press;
        logic [7:0]  ascii;
        logic        rd;
        logic        ack;
        logic [3:0]  cnt;
        logic [3:0]  vec;
        logic [63:0] data;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    function automatic vec_t mk(logic p, logic [7:0] a, logic r, logic k,
                                logic [3:0] c, logic [3:0] v, logic [63:0] d);
        vec_t t;
        t.press = p; t.ascii = a; t.rd = r; t.ack = k;
        t.cnt = c; t.vec = v; t.data = d;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press_key(input logic [7:0] c);
        key_pressed = 1'b1; ascii_code = c;
        @(posedge clk); @(negedge clk);
        key_pressed = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [63:0] exp);
        rd_en = 1'b1;
        @(posedge clk); #1;
        check(name, rd_data, exp);
        @(negedge clk);
        rd_en = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 8'h41, 0, 0, 1, 1'b0, 0);
        tbl[1]  = mk(1, 8'h41, 0, 0, 1, 1, 0);
        tbl[2]  = mk(0, 8'h00, 0, 1, 1, 0, 0);
        tbl[3]  = mk(0, 8'h00, 1, 0, 0, 0, V | 64'h41);
        tbl[4]  = mk(0, 8'h00, 0, 0, 0, 0, V | 64'h41);
        tbl[5]  = mk(0, 8'h00, 0, 0, 0, 0, V | 64'h41);
        tbl[6]  = mk(1, 8'h61, 0, 0, 1, 0, V | 64'h41);
        tbl[7]  = mk(0, 8'h00, 0, 0, 1, 1, V | 64'h41);
        tbl[8]  = mk(1, 8'h62, 0, 0, 2, 1, V | 64'h41);
        tbl[9]  = mk(0, 8'h00, 1, 0, 1, 1, V | 64'h61);
        tbl[10] = mk(0, 8'h00, 1, 0, 1, 1, V | 64'h61);
        tbl[11] = mk(0, 8'h00, 1, 0, 1, 1, V | 64'h61);
        tbl[12] = mk(0, 8'h00, 1, 0, 1, 1, V | 64'h61);
        tbl[13] = mk(0, 8'h00, 1, 0, 1, 1, V | 64'h61);
        tbl[14] = mk(0, 8'h00, 0, 0, 1, 1, V | 64'h61);
        tbl[15] = mk(0, 8'h00, 1, 1, 0, 0, V | 64'h62);
        tbl[16] = mk(0, 8'h00, 0, 0, 0, 0, V | 64'h62);
        tbl[17] = mk(0, 8'h00, 1, 0, 0, 0, 64'd0);
        tbl[18] = mk(1, 8'h33, 0, 0, 1, 0, 64'd0);
        tbl[19] = mk(0, 8'h00, 0, 0, 1, 1, 64'd0);
        tbl[20] = mk(1, 8'h00, 0, 0, 1, 1, 64'd0);
        tbl[21] = mk(0, 8'h00, 0, 1, 1, 0, 64'd0);
        tbl[22] = mk(1, 8'h44, 0, 0, 2, 0, 64'd0);
        tbl[23] = mk(0, 8'h00, 1, 0, 1, 0, V | 64'h33);
        tbl[24] = mk(0, 8'h00, 0, 0, 1, 0, V | 64'h33);
        tbl[25] = mk(0, 8'h00, 1, 0, 0, 0, V | 64'h44);
        tbl[26] = mk(0, 8'h00, 0, 0, 0, 0, V | 64'h44);
        tbl[27] = mk(0, 8'h00, 0, 0, 0, 0, V | 64'h44);
        tbl[28] = mk(1, 8'h55, 0, 0, 1, 0, V | 64'h44);
        tbl[29] = mk(0, 8'h00, 0, 0, 1, 1, V | 64'h44);

        reset = 1'b1; ascii_code = 8'd0; key_pressed = 1'b0; key_released = 1'b0;
        rd_en = 1'b0; interrupt_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_vector", 64'(interrupt_vector), 64'd0);
        check("reset_rd_data", rd_data, 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            key_pressed = tbl[i].press; ascii_code = tbl[i].ascii;
            rd_en = tbl[i].rd; interrupt_ack = tbl[i].ack;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d_vector", i), 64'(interrupt_vector), 64'(tbl[i].vec));
            check($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].data);
            check($sformatf("tbl%0d_overflow", i), 64'(overflow), 64'd0);
            @(negedge clk);
        end
        key_pressed = 1'b0; rd_en = 1'b0; interrupt_ack = 1'b0;

        // Nine presses into an eight-entry queue.
        do_reset();
        for (int i = 1; i <= 9; i++) press_key(8'(8'h10 + i));
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 1; i <= 8; i++) read_check($sformatf("ovf_read%0d", i), V | 64'(8'h10 + i));
        read_check("ovf_read_empty", 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Push and pop together on a full queue.
        do_reset();
        for (int i = 1; i <= 8; i++) press_key(8'(8'h20 + i));
        check("fullpp_pre_count", 64'(count), 64'd8);
        key_pressed = 1'b1; ascii_code = 8'h99; rd_en = 1'b1;
        @(posedge clk); #1;
        check("fullpp_count", 64'(count), 64'd8);
        check("fullpp_overflow", 64'(overflow), 64'd0);
        check("fullpp_data", rd_data, V | 64'h21);
        @(negedge clk);
        key_pressed = 1'b0; rd_en = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int i = 2; i <= 8; i++) read_check($sformatf("fullpp_read%0d", i), V | 64'(8'h20 + i));
        read_check("fullpp_read_ninth", V | 64'h99);
        check("fullpp_end_count", 64'(count), 64'd0);

        // Asynchronous reset with three entries queued and a pending request.
        do_reset();
        for (int i = 1; i <= 4; i++) press_key(8'(8'h30 + i));
        read_check("rst_pre_read", V | 64'h31);
        check("rst_pre_count", 64'(count), 64'd3);
        check("rst_pre_vector", 64'(interrupt_vector), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async_count", 64'(count), 64'd0);
        check("rst_async_vector", 64'(interrupt_vector), 64'd0);
        check("rst_async_rd_data", rd_data, 64'd0);
        check("rst_async_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        read_check("rst_post_read", 64'd0);
        check("rst_post_count", 64'(count), 64'd0);

`ifdef KEY_RELEASE_EVENT_EN
        do_reset();
        press_key(8'h7A);
        key_released = 1'b1;
        @(posedge clk); @(negedge clk);
        key_released = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rel_count", 64'(count), 64'd2);
        read_check("rel_read_press", V | 64'h07A);
        read_check("rel_read_release", V | 64'h17A);
        key_pressed = 1'b1; key_released = 1'b1; ascii_code = 8'h31;
        @(posedge clk); #1;
        check("rel_same_cycle_count", 64'(count), 64'd1);
        check("rel_same_cycle_overflow", 64'(overflow), 64'd1);
        @(negedge clk);
        key_pressed = 1'b0; key_released = 1'b0;
        @(posedge clk); @(negedge clk);
        read_check("rel_same_cycle_read", V | 64'h031);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
